// File: rtl/decode_stage.sv
// Instruction decode stage: field split, class decode, 1-entry
// output register, load-use bubble insertion and branch flush.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   flush           : kills the held entry, blocks this cycle's input
//   in_valid/ready  : fetch-side handshake, instruction word
//   out_valid/ready : downstream handshake
//   opcode, read_reg1, read_reg2, write_reg, immediate,
//   is_rtype, is_load, is_store, is_branch : held decode result
//   hazard_stall    : a load-use bubble is inserted this cycle
//   stall_count     : saturating bubble counter
module decode_stage #(
  parameter int INSTR_W     = 17,
  parameter int OPC_W       = 5,
  parameter int REG_AW      = 4,
  parameter int IMM_W       = 8,
  parameter int RTYPE_LIMIT = 5,
  parameter int BEQ_OPC     = 5,
  parameter int LOAD_OPC    = 6,
  parameter int STORE_OPC   = 7,
  parameter int SIGN_EXT    = 0,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   opcode,
  output logic [REG_AW-1:0]  read_reg1,
  output logic [REG_AW-1:0]  read_reg2,
  output logic [REG_AW-1:0]  write_reg,
  output logic [IMM_W-1:0]   immediate,
  output logic               is_rtype,
  output logic               is_load,
  output logic               is_store,
  output logic               is_branch,
  output logic               hazard_stall,
  output logic [CNT_W-1:0]   stall_count
);

  localparam logic [OPC_W-1:0] RLIM = OPC_W'(RTYPE_LIMIT);
  localparam logic [OPC_W-1:0] BEQ  = OPC_W'(BEQ_OPC);
  localparam logic [OPC_W-1:0] LDO  = OPC_W'(LOAD_OPC);
  localparam logic [OPC_W-1:0] STO  = OPC_W'(STORE_OPC);

  logic [OPC_W-1:0]  opc_in;
  logic [REG_AW-1:0] rs_in;
  logic [REG_AW-1:0] rt_in;
  logic [REG_AW-1:0] lo_in;
  logic signed [REG_AW-1:0] lo_s;
  logic [IMM_W-1:0]  imm_sx;
  logic              cls_a;
  logic              cls_b;

  assign opc_in = instruction[INSTR_W-1 -: OPC_W];
  assign rs_in  = instruction[3*REG_AW-1 : 2*REG_AW];
  assign rt_in  = instruction[2*REG_AW-1 : REG_AW];
  assign lo_in  = instruction[REG_AW-1:0];
  assign lo_s   = lo_in;
  assign imm_sx = IMM_W'(lo_s);
  assign cls_a  = opc_in < RLIM;
  assign cls_b  = opc_in[OPC_W-1] & ~cls_a;

  logic [REG_AW-1:0] dec_wr;
  logic [IMM_W-1:0]  dec_imm;
  logic              dec_rtype;
  logic              dec_load;
  logic              dec_store;
  logic              dec_branch;

  always_comb begin
    dec_wr     = lo_in;
    dec_imm    = '0;
    dec_rtype  = 1'b0;
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    dec_branch = 1'b0;
    unique case (1'b1)
      cls_a: dec_rtype = 1'b1;
      cls_b: dec_imm   = IMM_W'(rs_in);
      default: begin
        dec_wr     = rs_in;
        dec_imm    = (SIGN_EXT != 0) ? imm_sx
                                     : IMM_W'(lo_in);
        dec_load   = opc_in == LDO;
        dec_store  = opc_in == STO;
        dec_branch = opc_in == BEQ;
        if (opc_in == BEQ) dec_wr = '0;
      end
    endcase
  end

  logic              out_valid_q, out_valid_d;
  logic [OPC_W-1:0]  opcode_q, opcode_d;
  logic [REG_AW-1:0] read_reg1_q, read_reg1_d;
  logic [REG_AW-1:0] read_reg2_q, read_reg2_d;
  logic [REG_AW-1:0] write_reg_q, write_reg_d;
  logic [IMM_W-1:0]  immediate_q, immediate_d;
  logic              is_rtype_q, is_rtype_d;
  logic              is_load_q, is_load_d;
  logic              is_store_q, is_store_d;
  logic              is_branch_q, is_branch_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  logic hazard;
  logic accept;

  // rt is only a source operand for R-type instructions
  assign hazard = out_valid_q & is_load_q & in_valid &
                  ((write_reg_q == rs_in) |
                   (cls_a & (write_reg_q == rt_in)));

  assign in_ready = ~reset & ~flush & ~hazard &
                    (~out_valid_q | out_ready);
  assign accept       = in_valid & in_ready;
  assign hazard_stall = hazard & out_ready;

  always_comb begin
    out_valid_d   = out_valid_q;
    opcode_d      = opcode_q;
    read_reg1_d   = read_reg1_q;
    read_reg2_d   = read_reg2_q;
    write_reg_d   = write_reg_q;
    immediate_d   = immediate_q;
    is_rtype_d    = is_rtype_q;
    is_load_d     = is_load_q;
    is_store_d    = is_store_q;
    is_branch_d   = is_branch_q;
    stall_count_d = stall_count_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      opcode_d    = opc_in;
      read_reg1_d = rs_in;
      read_reg2_d = rt_in;
      write_reg_d = dec_wr;
      immediate_d = dec_imm;
      is_rtype_d  = dec_rtype;
      is_load_d   = dec_load;
      is_store_d  = dec_store;
      is_branch_d = dec_branch;
    end else if (out_ready) begin
      // plain consume, or the load retiring ahead of a bubble
      out_valid_d = 1'b0;
    end
    if (~flush & hazard_stall & ~(&stall_count_q))
      stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      opcode_q      <= '0;
      read_reg1_q   <= '0;
      read_reg2_q   <= '0;
      write_reg_q   <= '0;
      immediate_q   <= '0;
      is_rtype_q    <= 1'b0;
      is_load_q     <= 1'b0;
      is_store_q    <= 1'b0;
      is_branch_q   <= 1'b0;
      stall_count_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      opcode_q      <= opcode_d;
      read_reg1_q   <= read_reg1_d;
      read_reg2_q   <= read_reg2_d;
      write_reg_q   <= write_reg_d;
      immediate_q   <= immediate_d;
      is_rtype_q    <= is_rtype_d;
      is_load_q     <= is_load_d;
      is_store_q    <= is_store_d;
      is_branch_q   <= is_branch_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign opcode      = opcode_q;
  assign read_reg1   = read_reg1_q;
  assign read_reg2   = read_reg2_q;
  assign write_reg   = write_reg_q;
  assign immediate   = immediate_q;
  assign is_rtype    = is_rtype_q;
  assign is_load     = is_load_q;
  assign is_store    = is_store_q;
  assign is_branch   = is_branch_q;
  assign stall_count = stall_count_q;

endmodule
